// File: rtl/seg_add_unit.sv
// Multi-cycle adder/subtractor that processes SEG_W bits per clock, starting with the LSB segment.
// Define SEG_ADD_FLAGS_EN to add the zero and signed-overflow (ovf) result flags.
module seg_add_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SEG_ADD_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int unsigned NSEG  = WIDTH / SEG_W;
    localparam int unsigned IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG_W{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               last_seg;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry;
    logic [IDX_W-1:0]   seg_idx;
    logic [31:0]        seg_base;
    logic [SEG_W-1:0]   a_seg;
    logic [SEG_W-1:0]   b_seg;
    logic [SEG_W:0]     seg_sum;
    logic [WIDTH-1:0]   result_nxt;
`ifdef SEG_ADD_FLAGS_EN
    logic               msb_cin;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_seg) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Add one segment. The new sum bits are merged into their slice of the result.
    always_comb begin
        seg_base   = 32'(seg_idx) * SEG_W;
        a_seg      = SEG_W'(a_q >> seg_base);
        b_seg      = SEG_W'(b_q >> seg_base);
        seg_sum    = {1'b0, a_seg} + {1'b0, b_seg} + (SEG_W + 1)'(carry);
        result_nxt = (result & ~(SEG_MASK << seg_base))
                   | (WIDTH'(seg_sum[SEG_W-1:0]) << seg_base);
        last_seg   = (seg_idx == IDX_W'(NSEG - 1));
`ifdef SEG_ADD_FLAGS_EN
        msb_cin    = seg_sum[SEG_W-1] ^ a_seg[SEG_W-1] ^ b_seg[SEG_W-1];
`endif
    end

    // Operand capture, segment sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            seg_idx   <= '0;
            result    <= '0;
            cout      <= 1'b0;
`ifdef SEG_ADD_FLAGS_EN
            zero      <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            if (accept) begin
                a_q     <= a;
                b_q     <= b ^ {WIDTH{sub}};
                carry   <= sub;
                seg_idx <= '0;
            end else if (state == RUN) begin
                result  <= result_nxt;
                carry   <= seg_sum[SEG_W];
                seg_idx <= seg_idx + IDX_W'(1);
                if (last_seg) begin
                    cout <= seg_sum[SEG_W];
`ifdef SEG_ADD_FLAGS_EN
                    zero <= (result_nxt == '0);
                    ovf  <= msb_cin ^ seg_sum[SEG_W];
`endif
                end
            end
        end
    end

endmodule
